dmem_responder: RTL

//  Data-memory responder: the memory end of the processor load/store port.

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one word load/store per valid/ready transaction, WAIT_CYCLES wait states.
// Optional address checking (misaligned / out-of-range -> rsp_err) enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [AW-1:0]   idx_reg;
  logic            write_reg;
  logic            err_reg;
  logic [31:0]     wdata_reg;
  logic [31:0]     rdata_reg;
  logic            rsp_err_reg;
  logic            enter_resp;

  logic [31:0]     mem [DEPTH];

  logic            req_bad;
  logic [AW-1:0]   req_idx;
  logic [AW-1:0]   acc_idx;
  logic            acc_write;
  logic            acc_err;
  logic [31:0]     acc_wdata;
  logic            mem_we;

  assign req_idx = req_addr[AW+1:2];

`ifdef DMEM_ADDR_CHECK_EN
  assign req_bad = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH * 4));
`else
  assign req_bad = 1'b0;
`endif

  // Address bits outside the word index only matter when checking is enabled.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  // With zero wait states the array is accessed on the accept edge itself,
  // before the request registers have been loaded, so use the live inputs.
  assign acc_idx   = (state_reg == S_IDLE) ? req_idx   : idx_reg;
  assign acc_write = (state_reg == S_IDLE) ? req_write : write_reg;
  assign acc_err   = (state_reg == S_IDLE) ? req_bad   : err_reg;
  assign acc_wdata = (state_reg == S_IDLE) ? req_wdata : wdata_reg;

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = rsp_err_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Commit is gated by reset so an interrupted store never lands.
  assign mem_we = rst_n && enter_resp && acc_write && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 4'd0;
      idx_reg     <= '0;
      write_reg   <= 1'b0;
      err_reg     <= 1'b0;
      wdata_reg   <= 32'd0;
      rdata_reg   <= 32'd0;
      rsp_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == S_IDLE && req_valid) begin
        idx_reg   <= req_idx;
        write_reg <= req_write;
        err_reg   <= req_bad;
        wdata_reg <= req_wdata;
      end
      if (enter_resp) begin
        rdata_reg   <= (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
        rsp_err_reg <= acc_err;
      end
    end
  end

endmodule
